scr1_dmi_arb: RTL and testbench

SCR1_DMI_ARB -- requirements
Module: scr1_dmi_arb

---
 rtl/scr1_dmi_arb.sv | 225 ++++++++++++++++++++++
 tb/tb_scr1_dmi_arb.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_dmi_arb.sv
//-----------------------------------------------------------------------------
// scr1_dmi_arb
//
// Two-requester arbiter in front of the Debug Module Interface (DMI).
// Requester 0 is the TAP DMI and requester 1 is the system debug port. One
// access is in flight at a time. Each access goes through
// IDLE -> BUSY -> DONE -> IDLE.
//
// Optional feature (macro SCR1_DMI_ARB_TIMEOUT_EN):
//   When defined, a BUSY phase that sees no DM response for TIMEOUT_CYCLES
//   cycles is aborted. The abort is reported in DONE with err_o = 1.
//   When undefined, BUSY waits forever, err_o is tied low and no counter
//   exists.
//
// Ports:
//   clk, rst_n          single clock, synchronous active-low reset
//   req_i[1:0]          request, one bit per requester
//   wr_i[1:0]           write flag per requester
//   addr_i / wdata_i    per-requester address / write data; slice k belongs
//                       to requester k
//   gnt_o[1:0]          one-hot accept pulse (combinational, IDLE only)
//   resp_o[1:0]         one-hot completion pulse to the owner (DONE only)
//   rdata_o, err_o      completion data and abort flag, zero outside DONE
//   dmi2dm_*_o          request to the DM; address, data and write flag are
//                       zero whenever dmi2dm_req_o is low
//   dm2dmi_resp_i/_rdata_i  DM response and read data (used in BUSY only)
//-----------------------------------------------------------------------------
`ifndef SCR1_DBG_DMI_ADDR_WIDTH
`define SCR1_DBG_DMI_ADDR_WIDTH 7
`endif
`ifndef SCR1_DBG_DMI_DATA_WIDTH
`define SCR1_DBG_DMI_DATA_WIDTH 32
`endif

module scr1_dmi_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [1:0]                            req_i,
  input  logic [1:0]                            wr_i,
  input  logic [2*`SCR1_DBG_DMI_ADDR_WIDTH-1:0] addr_i,
  input  logic [2*`SCR1_DBG_DMI_DATA_WIDTH-1:0] wdata_i,
  output logic [1:0]                            gnt_o,
  output logic [1:0]                            resp_o,
  output logic [`SCR1_DBG_DMI_DATA_WIDTH-1:0]   rdata_o,
  output logic                                  err_o,
  output logic                                  dmi2dm_req_o,
  output logic                                  dmi2dm_wr_o,
  output logic [`SCR1_DBG_DMI_ADDR_WIDTH-1:0]   dmi2dm_addr_o,
  output logic [`SCR1_DBG_DMI_DATA_WIDTH-1:0]   dmi2dm_wdata_o,
  input  logic                                  dm2dmi_resp_i,
  input  logic [`SCR1_DBG_DMI_DATA_WIDTH-1:0]   dm2dmi_rdata_i
);

  localparam int unsigned AW = `SCR1_DBG_DMI_ADDR_WIDTH;
  localparam int unsigned DW = `SCR1_DBG_DMI_DATA_WIDTH;
  localparam logic [7:0]  TO_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;     // requester granted most recently
  logic            owner_q, owner_d;   // requester owning the current access
  logic            cmd_wr_q, cmd_wr_d;
  logic [AW-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DW-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            win_s;
  logic [1:0]      gnt_s;

`ifdef SCR1_DMI_ARB_TIMEOUT_EN
  logic            err_q, err_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            to_hit_s;

  // cnt_q counts BUSY cycles already completed; this cycle is number
  // cnt_q + 1, and the access aborts when that reaches the limit.
  assign to_hit_s = ((cnt_q + 8'd1) == TO_LIMIT);
`else
  logic            unused_timeout_s;

  // The limit is meaningless without the timeout feature.
  assign unused_timeout_s = ^TO_LIMIT;
`endif

  // Round-robin winner: a lone requester wins; on contention the requester
  // not granted last time wins.
  always_comb begin
    if (req_i == 2'b11) begin
      win_s = ~last_q;
    end else begin
      win_s = req_i[1];
    end
  end

  // Next-state and register-update logic of the access FSM.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rdata_d     = rdata_q;
    gnt_s       = 2'b00;
`ifdef SCR1_DMI_ARB_TIMEOUT_EN
    err_d       = err_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_i != 2'b00) begin
          gnt_s       = 2'b01 << win_s;
          last_d      = win_s;
          owner_d     = win_s;
          cmd_wr_d    = wr_i[win_s];
          cmd_addr_d  = addr_i[win_s*AW +: AW];
          cmd_wdata_d = wdata_i[win_s*DW +: DW];
`ifdef SCR1_DMI_ARB_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
          state_d     = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (dm2dmi_resp_i) begin
          // A response in the limit cycle still completes normally.
          rdata_d = cmd_wr_q ? {DW{1'b0}} : dm2dmi_rdata_i;
`ifdef SCR1_DMI_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = ST_DONE;
`ifdef SCR1_DMI_ARB_TIMEOUT_EN
        end else if (to_hit_s) begin
          rdata_d = {DW{1'b0}};
          err_d   = 1'b1;
          state_d = ST_DONE;
`endif
        end else begin
`ifdef SCR1_DMI_ARB_TIMEOUT_EN
          cnt_d   = cnt_q + 8'd1;
`endif
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= {AW{1'b0}};
      cmd_wdata_q <= {DW{1'b0}};
      rdata_q     <= {DW{1'b0}};
`ifdef SCR1_DMI_ARB_TIMEOUT_EN
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rdata_q     <= rdata_d;
`ifdef SCR1_DMI_ARB_TIMEOUT_EN
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Output decode. Everything is forced low while rst_n is asserted so the
  // outputs are quiet even before the first reset edge has been seen.
  always_comb begin
    gnt_o          = 2'b00;
    resp_o         = 2'b00;
    rdata_o        = {DW{1'b0}};
    err_o          = 1'b0;
    dmi2dm_req_o   = 1'b0;
    dmi2dm_wr_o    = 1'b0;
    dmi2dm_addr_o  = {AW{1'b0}};
    dmi2dm_wdata_o = {DW{1'b0}};
    if (rst_n) begin
      gnt_o = gnt_s;
      if (state_q == ST_BUSY) begin
        dmi2dm_req_o   = 1'b1;
        dmi2dm_wr_o    = cmd_wr_q;
        dmi2dm_addr_o  = cmd_addr_q;
        dmi2dm_wdata_o = cmd_wdata_q;
      end else if (state_q == ST_DONE) begin
        resp_o  = 2'b01 << owner_q;
        rdata_o = rdata_q;
`ifdef SCR1_DMI_ARB_TIMEOUT_EN
        err_o   = err_q;
`else
        err_o   = 1'b0;
`endif
      end else begin
        dmi2dm_req_o = 1'b0;
      end
    end else begin
      gnt_o = 2'b00;
    end
  end

endmodule

// File: tb/tb_scr1_dmi_arb.sv
`timescale 1ns/1ps
`ifndef SCR1_DBG_DMI_ADDR_WIDTH
`define SCR1_DBG_DMI_ADDR_WIDTH 7
`endif
`ifndef SCR1_DBG_DMI_DATA_WIDTH
`define SCR1_DBG_DMI_DATA_WIDTH 32
`endif

module tb_scr1_dmi_arb;

  localparam int AW = `SCR1_DBG_DMI_ADDR_WIDTH;
  localparam int DW = `SCR1_DBG_DMI_DATA_WIDTH;
`ifdef SCR1_DMI_ARB_TIMEOUT_EN
  localparam int TO     = 4;
  localparam int MAXD   = 3;   // stay below the limit in normal traffic
  localparam int SLOW_D = 3;
`else
  localparam int TO     = 255;
  localparam int MAXD   = 6;
  localparam int SLOW_D = 5;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        req_i = 2'b00;
  logic [1:0]        wr_i = 2'b00;
  logic [2*AW-1:0]   addr_i = '0;
  logic [2*DW-1:0]   wdata_i = '0;
  logic [1:0]        gnt_o, resp_o;
  logic [DW-1:0]     rdata_o;
  logic              err_o;
  logic              dmi2dm_req_o, dmi2dm_wr_o;
  logic [AW-1:0]     dmi2dm_addr_o;
  logic [DW-1:0]     dmi2dm_wdata_o;
  logic              dm2dmi_resp_i = 1'b0;
  logic [DW-1:0]     dm2dmi_rdata_i = '0;

  int checks = 0;
  int errors = 0;
  int model_last = 1;   // reference round-robin pointer

  scr1_dmi_arb #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .wr_i           (wr_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .gnt_o          (gnt_o),
    .resp_o         (resp_o),
    .rdata_o        (rdata_o),
    .err_o          (err_o),
    .dmi2dm_req_o   (dmi2dm_req_o),
    .dmi2dm_wr_o    (dmi2dm_wr_o),
    .dmi2dm_addr_o  (dmi2dm_addr_o),
    .dmi2dm_wdata_o (dmi2dm_wdata_o),
    .dm2dmi_resp_i  (dm2dmi_resp_i),
    .dm2dmi_rdata_i (dm2dmi_rdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [2*DW-1:0] rand_wdata();
    logic [2*DW-1:0] v;
    for (int b = 0; b < 2*DW; b++) v[b] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [2*AW-1:0] rand_addr();
    logic [2*AW-1:0] v;
    for (int b = 0; b < 2*AW; b++) v[b] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] v;
    for (int b = 0; b < DW; b++) v[b] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // One complete access: request, `delay` BUSY cycles with the DM answering
  // in the last one, then DONE. Expectations come from the round-robin rule
  // and the cycle-level latency rules.
  task automatic run_access(input logic [1:0] req, input logic [1:0] wr,
                            input logic [2*AW-1:0] addr, input logic [2*DW-1:0] wdata,
                            input int delay, input logic [DW-1:0] dm_data, input string tag);
    int            w;
    logic [1:0]    exp_gnt;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    w = (req == 2'b11) ? ((model_last == 1) ? 0 : 1) : ((req == 2'b10) ? 1 : 0);
    model_last = w;
    exp_gnt = (w == 1) ? 2'b10 : 2'b01;
    e_wr    = wr[w];
    e_addr  = addr[w*AW +: AW];
    e_wdata = wdata[w*DW +: DW];
    e_rdata = e_wr ? '0 : dm_data;

    @(negedge clk);
    req_i = req; wr_i = wr; addr_i = addr; wdata_i = wdata;
    dm2dmi_resp_i = 1'b0; dm2dmi_rdata_i = rand_word();
    #1;
    checks++;
    if (gnt_o !== exp_gnt || resp_o !== 2'b00 || dmi2dm_req_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_grant: got gnt=%b resp=%b dmreq=%b expected gnt=%b resp=00 dmreq=0",
               tag, gnt_o, resp_o, dmi2dm_req_o, exp_gnt);
    end

    for (int i = 1; i <= delay; i++) begin
      @(negedge clk);
      // Scramble the requester inputs; the DM side must keep the latched command.
      wr_i = 2'($urandom_range(0, 3)); addr_i = rand_addr(); wdata_i = rand_wdata();
      dm2dmi_resp_i  = (i == delay);
      dm2dmi_rdata_i = (i == delay) ? dm_data : rand_word();
      #1;
      checks++;
      if (dmi2dm_req_o !== 1'b1 || dmi2dm_wr_o !== e_wr || dmi2dm_addr_o !== e_addr ||
          dmi2dm_wdata_o !== e_wdata || gnt_o !== 2'b00 || resp_o !== 2'b00 ||
          rdata_o !== '0 || err_o !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy%0d: got req=%b wr=%b addr=%h wdata=%h gnt=%b resp=%b rdata=%h err=%b expected req=1 wr=%b addr=%h wdata=%h gnt=00 resp=00 rdata=0 err=0",
                 tag, i, dmi2dm_req_o, dmi2dm_wr_o, dmi2dm_addr_o, dmi2dm_wdata_o, gnt_o,
                 resp_o, rdata_o, err_o, e_wr, e_addr, e_wdata);
      end
    end

    @(negedge clk);
    req_i = req;   // requests during DONE must be ignored
    dm2dmi_resp_i = 1'($urandom_range(0, 1)); dm2dmi_rdata_i = rand_word();
    #1;
    checks++;
    if (resp_o !== exp_gnt || rdata_o !== e_rdata || err_o !== 1'b0 || gnt_o !== 2'b00 ||
        dmi2dm_req_o !== 1'b0 || dmi2dm_wr_o !== 1'b0 || dmi2dm_addr_o !== '0 ||
        dmi2dm_wdata_o !== '0) begin
      errors++;
      $display("FAIL %s_done: got resp=%b rdata=%h err=%b gnt=%b dmreq=%b expected resp=%b rdata=%h err=0 gnt=00 dmreq=0",
               tag, resp_o, rdata_o, err_o, gnt_o, dmi2dm_req_o, exp_gnt, e_rdata);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    req_i = 2'b00; dm2dmi_resp_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req_i = 2'b11; wr_i = 2'b11; addr_i = rand_addr(); wdata_i = rand_wdata();
    dm2dmi_resp_i = 1'b1; dm2dmi_rdata_i = rand_word();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({gnt_o, resp_o, err_o, dmi2dm_req_o, dmi2dm_wr_o} !== 7'b0 || rdata_o !== '0 ||
          dmi2dm_addr_o !== '0 || dmi2dm_wdata_o !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got gnt=%b resp=%b rdata=%h err=%b dmreq=%b expected all zero",
                 gnt_o, resp_o, rdata_o, err_o, dmi2dm_req_o);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; req_i = 2'b00; dm2dmi_resp_i = 1'b0;
    #1;
    checks++;
    if (gnt_o !== 2'b00 || resp_o !== 2'b00 || dmi2dm_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got gnt=%b resp=%b dmreq=%b expected 00 00 0", gnt_o, resp_o, dmi2dm_req_o);
    end
    model_last = 1;
  endtask

  task automatic test_contention();
    for (int k = 0; k < 3; k++)
      run_access(2'b11, 2'b00, rand_addr(), rand_wdata(), 1, rand_word(), "contention");
    go_idle();
  endtask

  task automatic test_single_read();
    logic [2*AW-1:0] a;
    a = rand_addr();
    a[AW-1:0] = 7'h11;
    run_access(2'b01, 2'b00, a, rand_wdata(), 1, 32'hDEADBEEF, "single_read");
    go_idle();
  endtask

  task automatic test_slow_write();
    logic [2*AW-1:0] a;
    logic [2*DW-1:0] d;
    a = rand_addr(); d = rand_wdata();
    a[AW-1:0] = 7'h10;
    d[DW-1:0] = 32'h12345678;
    run_access(2'b01, 2'b01, a, d, SLOW_D, rand_word(), "slow_write");
    go_idle();
  endtask

  task automatic test_idle_resp_ignored();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_i = 2'b00; dm2dmi_resp_i = 1'b1; dm2dmi_rdata_i = rand_word();
      #1;
      checks++;
      if (resp_o !== 2'b00 || rdata_o !== '0 || dmi2dm_req_o !== 1'b0 || gnt_o !== 2'b00) begin
        errors++;
        $display("FAIL idle_resp: got resp=%b rdata=%h dmreq=%b gnt=%b expected all zero",
                 resp_o, rdata_o, dmi2dm_req_o, gnt_o);
      end
    end
    run_access(2'b10, 2'b00, rand_addr(), rand_wdata(), 2, rand_word(), "after_idle_resp");
    go_idle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      run_access(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), rand_addr(), rand_wdata(),
                 $urandom_range(1, MAXD), rand_word(), "random");
    go_idle();
  endtask

  task automatic test_reset_mid_busy();
    run_access(2'b01, 2'b00, rand_addr(), rand_wdata(), 1, rand_word(), "pre_reset");
    @(negedge clk);
    req_i = 2'b01; wr_i = 2'b00; addr_i = rand_addr(); dm2dmi_resp_i = 1'b0;
    model_last = 0;
    #1;
    checks++;
    if (gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL midbusy_grant: got %b expected 01", gnt_o);
    end
    @(negedge clk);
    req_i = 2'b00;
    @(negedge clk);
    rst_n = 1'b0; dm2dmi_resp_i = 1'b1; dm2dmi_rdata_i = rand_word();
    #1;
    checks++;
    if (dmi2dm_req_o !== 1'b0 || resp_o !== 2'b00 || gnt_o !== 2'b00 || rdata_o !== '0) begin
      errors++;
      $display("FAIL midbusy_reset_out: got dmreq=%b resp=%b gnt=%b rdata=%h expected all zero",
               dmi2dm_req_o, resp_o, gnt_o, rdata_o);
    end
    model_last = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rst_n = 1'b1; dm2dmi_resp_i = 1'b0;
      #1;
      checks++;
      if (resp_o !== 2'b00 || dmi2dm_req_o !== 1'b0 || err_o !== 1'b0) begin
        errors++;
        $display("FAIL midbusy_no_resp: got resp=%b dmreq=%b err=%b expected 00 0 0",
                 resp_o, dmi2dm_req_o, err_o);
      end
    end
    run_access(2'b11, 2'b00, rand_addr(), rand_wdata(), 1, rand_word(), "post_reset");
    go_idle();
  endtask

`ifdef SCR1_DMI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    // Response in the limit cycle completes normally.
    run_access(2'b10, 2'b00, rand_addr(), rand_wdata(), TO, rand_word(), "limit_resp");
    @(negedge clk);
    req_i = 2'b10; wr_i = 2'b00; dm2dmi_resp_i = 1'b0;
    model_last = 1;
    #1;
    checks++;
    if (gnt_o !== 2'b10) begin
      errors++;
      $display("FAIL timeout_grant: got %b expected 10", gnt_o);
    end
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      req_i = 2'b00; dm2dmi_rdata_i = rand_word();
      #1;
      checks++;
      if (dmi2dm_req_o !== 1'b1 || resp_o !== 2'b00) begin
        errors++;
        $display("FAIL timeout_busy%0d: got dmreq=%b resp=%b expected 1 00", i, dmi2dm_req_o, resp_o);
      end
    end
    @(negedge clk);
    dm2dmi_resp_i = 1'b1; dm2dmi_rdata_i = rand_word();   // late response
    #1;
    checks++;
    if (dmi2dm_req_o !== 1'b0 || resp_o !== 2'b10 || err_o !== 1'b1 || rdata_o !== '0) begin
      errors++;
      $display("FAIL timeout_done: got dmreq=%b resp=%b err=%b rdata=%h expected 0 10 1 0",
               dmi2dm_req_o, resp_o, err_o, rdata_o);
    end
    @(negedge clk);
    dm2dmi_resp_i = 1'b1;
    #1;
    checks++;
    if (resp_o !== 2'b00 || err_o !== 1'b0 || dmi2dm_req_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_late_resp: got resp=%b err=%b dmreq=%b expected 00 0 0",
               resp_o, err_o, dmi2dm_req_o);
    end
    go_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_slow_write();
    test_idle_resp_ignored();
    test_random();
    test_reset_mid_busy();
`ifdef SCR1_DMI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
